fm_wm_source_memory: RTL and testbench
======================================

Name: fm_wm_source_memory

Overview:
- Read-side responder for the transformation datapath. Serves the `enable_read` / `read_address` requests issued by the transformation control and returns full 96-element vectors on its `data_in` bus.
- Holds WEIGHT_COLS weight columns at addresses WEIGHT_BASE+i and FEATURE_ROWS feature rows at FEATURE_BASE+i.
- Contents are filled beforehand through an element-serial valid/ready load stream. `mem_loaded` gates the transformation `start`.

Parameters:
- VEC_LEN, 96, elements per stored vector (= WEIGHT_ROWS = FEATURE_COLS)
- ELEM_WIDTH, 5, bits per element
- WEIGHT_COLS, 3, number of weight-column entries
- FEATURE_ROWS, 6, number of feature-row entries
- ADDRESS_WIDTH, 13, read address width
- WEIGHT_BASE, 13'h000, address of weight column 0
- FEATURE_BASE, 13'h200, address of feature row 0

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse: begin (re)loading all entries
- load_valid  in  1  load element valid
- load_data  in  ELEM_WIDTH  load element
- load_ready  out  1  block accepts load element this cycle
- load_done  out  1  one-cycle pulse after final element is stored
- mem_loaded  out  1  level: contents complete, reads are served
- read_en  in  1  read request (driven by enable_read)
- read_address  in  ADDRESS_WIDTH  requested entry
- data_out  out  ELEM_WIDTH x VEC_LEN (unpacked [0:VEC_LEN-1])  vector returned to the datapath `data_in`
- data_valid  out  1  one-cycle pulse: data_out updated this cycle
- addr_err  out  1  sticky out-of-range flag (only with FWM_ADDR_CHECK_EN)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All storage, data_out, counters: 0.
  - load_ready=0, load_done=0, mem_loaded=0, data_valid=0, addr_err=0.
- FSM states: IDLE, LOAD, LOADED.
  - IDLE --load_start--> LOAD.
  - LOAD --final element accepted--> LOADED.
  - LOADED --load_start--> LOAD.
  - load_start during LOAD restarts the counters at 0; already-written data is not cleared.
- LOAD:
  - load_ready=1.
  - An element is accepted when load_valid && load_ready.
  - elem_cnt (0..VEC_LEN-1) and entry_cnt (0..WEIGHT_COLS+FEATURE_ROWS-1) advance per accepted element.
  - Order: weight column 0 elements 0..95, column 1, column 2, then feature row 0..5, each element-ascending.
  - elem_cnt wraps 95->0 and increments entry_cnt.
  - On the last element (entry 8, elem 95): next cycle load_done=1 for exactly one cycle, mem_loaded=1, load_ready=0.
  - mem_loaded clears in the cycle after load_start.
- Reads:
  - Served only in LOADED.
  - read_en=1 at edge N: data_out and data_valid=1 are visible after edge N+1 (1-cycle latency).
  - Back-to-back reads every cycle are supported, one result per cycle.
  - data_out holds its last value when there is no read. data_valid=0 on idle cycles.
- Address decode:
  - [WEIGHT_BASE, WEIGHT_BASE+WEIGHT_COLS) -> weight entry.
  - [FEATURE_BASE, FEATURE_BASE+FEATURE_ROWS) -> feature entry.
  - Any other address: data_out=all zeros, data_valid=1.
- read_en while not LOADED: ignored. data_out unchanged, data_valid=0.
- read_en and load_start in the same LOADED cycle: the read is served from the old contents, and LOAD begins.
- Reset mid-load or mid-read: the operation is abandoned, all state returns to reset values, and contents are cleared.
- No arithmetic on data. Elements are stored and returned bit-exact, unsigned.

Optional Feature:
- FWM_ADDR_CHECK_EN defined:
  - addr_err sets 1 the cycle after any read_en in LOADED with an out-of-range address.
  - It also sets on any read_en in IDLE or LOAD.
  - Sticky; cleared only by reset or load_start.
- Not defined: addr_err is tied to 0, and no check logic is present.

Test Plan:
- Load stream, weight[c][k]=(c+k)%32, feature[r][k]=(3r+k)%32, load_valid held 1 -> load_done pulses once, 864 cycles after the first accept; mem_loaded=1.
- Read addr 13'h001 then 13'h205 on consecutive cycles -> data_out matches weight column 1, then feature row 5, each 1 cycle after its request; data_valid=1 for 2 cycles.
- Read addr 13'h003 and 13'h206 -> data_out all zeros, data_valid=1; addr_err=1 with FWM_ADDR_CHECK_EN, 0 without.
- read_en=1 while in LOAD (elem 40 of entry 2) -> data_valid stays 0 and data_out unchanged; load completes normally.
- load_start coincident with read of 13'h000 in LOADED -> old weight column 0 returned; mem_loaded=0 next cycle; reload with new values; reread shows new data.
- Assert reset=0 mid-load (entry 4) -> all outputs 0 immediately; after release, reads ignored until a full reload.

Source files
------------

// File: rtl/fm_wm_source_memory.sv
// Vector source memory for the transformation datapath: element-serial load stream in,
// whole-vector reads out with one cycle of latency. Define FWM_ADDR_CHECK_EN for the sticky addr_err flag.
module fm_wm_source_memory #(
  parameter int                         VEC_LEN       = 96,
  parameter int                         ELEM_WIDTH    = 5,
  parameter int                         WEIGHT_COLS   = 3,
  parameter int                         FEATURE_ROWS  = 6,
  parameter int                         ADDRESS_WIDTH = 13,
  parameter logic [ADDRESS_WIDTH-1:0]   WEIGHT_BASE   = 'h000,
  parameter logic [ADDRESS_WIDTH-1:0]   FEATURE_BASE  = 'h200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [ELEM_WIDTH-1:0]    load_data,
  output logic                     load_ready,
  output logic                     load_done,
  output logic                     mem_loaded,
  input  logic                     read_en,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [ELEM_WIDTH-1:0]    data_out [0:VEC_LEN-1],
  output logic                     data_valid,
  output logic                     addr_err
);

  localparam int ENTRIES = WEIGHT_COLS + FEATURE_ROWS;
  localparam int ENTRY_W = $clog2(ENTRIES);
  localparam int ELEM_W  = $clog2(VEC_LEN);

  typedef enum logic [1:0] {IDLE, LOAD, LOADED} state_t;

  state_t                   state;
  logic [ELEM_W-1:0]        elem_cnt;
  logic [ENTRY_W-1:0]       entry_cnt;
  logic [ELEM_WIDTH-1:0]    mem [0:ENTRIES-1][0:VEC_LEN-1];

  logic                     accept;
  logic                     last_elem;
  logic [ADDRESS_WIDTH-1:0] w_off;
  logic [ADDRESS_WIDTH-1:0] f_off;
  logic                     rd_hit;
  logic [ENTRY_W-1:0]       rd_entry;

  // load_ready is high exactly while in LOAD; a restart pulse wins over a coincident element.
  assign accept    = load_ready && load_valid && !load_start;
  assign last_elem = (entry_cnt == ENTRY_W'(ENTRIES - 1)) && (elem_cnt == ELEM_W'(VEC_LEN - 1));

  // Offsets wrap below each base, so a single upper-bound compare decodes each window.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_off    = read_address - WEIGHT_BASE;
    f_off    = read_address - FEATURE_BASE;
    rd_hit   = 1'b0;
    rd_entry = '0;
    if (w_off < ADDRESS_WIDTH'(WEIGHT_COLS)) begin
      rd_hit   = 1'b1;
      rd_entry = ENTRY_W'(w_off);
    end else if (f_off < ADDRESS_WIDTH'(FEATURE_ROWS)) begin
      rd_hit   = 1'b1;
      rd_entry = ENTRY_W'(f_off) + ENTRY_W'(WEIGHT_COLS);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      elem_cnt   <= '0;
      entry_cnt  <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      mem_loaded <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            load_ready <= 1'b1;
            elem_cnt   <= '0;
            entry_cnt  <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            elem_cnt  <= '0;
            entry_cnt <= '0;
          end else if (accept) begin
            if (last_elem) begin
              state      <= LOADED;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
              mem_loaded <= 1'b1;
              elem_cnt   <= '0;
              entry_cnt  <= '0;
            end else if (elem_cnt == ELEM_W'(VEC_LEN - 1)) begin
              elem_cnt  <= '0;
              entry_cnt <= entry_cnt + 1'b1;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
            end
          end
        end
        LOADED: begin
          if (load_start) begin
            state      <= LOAD;
            load_ready <= 1'b1;
            mem_loaded <= 1'b0;
            elem_cnt   <= '0;
            entry_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: storage is cleared by reset because an abandoned load must not leave stale vectors readable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < ENTRIES; e++)
        for (int k = 0; k < VEC_LEN; k++)
          mem[e][k] <= '0;
    end else if (accept) begin
      mem[entry_cnt][elem_cnt] <= load_data;
    end
  end

  // Read port: a read coincident with load_start in LOADED still sees the old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_valid <= 1'b0;
      for (int k = 0; k < VEC_LEN; k++)
        data_out[k] <= '0;
    end else begin
      data_valid <= 1'b0;
      if (read_en && state == LOADED) begin
        data_valid <= 1'b1;
        if (rd_hit) begin
          data_out <= mem[rd_entry];
        end else begin
          for (int k = 0; k < VEC_LEN; k++)
            data_out[k] <= '0;
        end
      end
    end
  end

`ifdef FWM_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if (load_start) begin
      addr_err <= 1'b0;
    end else if (read_en && (state != LOADED || !rd_hit)) begin
      addr_err <= 1'b1;
    end
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_fm_wm_source_memory.sv
// Randomized bench for fm_wm_source_memory against an array-based reference of the
// stored vectors, the loaded flag and the sticky address-error flag.
module tb_fm_wm_source_memory;

  localparam int VL = 96;
  localparam int EW = 5;
  localparam int WC = 3;
  localparam int FR = 6;
  localparam int NENT = WC + FR;
  localparam int NE = NENT * VL;
  localparam int WB = 'h000;
  localparam int FB = 'h200;

  logic          clk;
  logic          reset;
  logic          load_start;
  logic          load_valid;
  logic [EW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic          mem_loaded;
  logic          read_en;
  logic [12:0]   read_address;
  logic [EW-1:0] data_out [0:VL-1];
  logic          data_valid;
  logic          addr_err;

  fm_wm_source_memory dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .load_done    (load_done),
    .mem_loaded   (mem_loaded),
    .read_en      (read_en),
    .read_address (read_address),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .addr_err     (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference state
  logic [EW-1:0] m_mem [0:NENT-1][0:VL-1];
  logic [EW-1:0] m_out [0:VL-1];
  bit            m_loaded;
  bit            m_err;

  task automatic check(input string tag, input logic [VL*EW-1:0] got, input logic [VL*EW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VL*EW-1:0] pack(input logic [EW-1:0] v [0:VL-1]);
    logic [VL*EW-1:0] p;
    for (int k = 0; k < VL; k++) p[k*EW +: EW] = v[k];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    for (int e = 0; e < NENT; e++)
      for (int k = 0; k < VL; k++) m_mem[e][k] = '0;
    for (int k = 0; k < VL; k++) m_out[k] = '0;
    m_loaded = 0;
    m_err    = 0;
  endtask

  // Predicts the effect of one request on data_out/addr_err; returns the expected data_valid.
  function automatic bit expect_read(input bit en, input int addr);
    if (!en) return 1'b0;
    if (!m_loaded) begin
`ifdef FWM_ADDR_CHECK_EN
      m_err = 1;
`endif
      return 1'b0;
    end
    if (addr >= WB && addr < WB + WC) begin
      m_out = m_mem[addr - WB];
    end else if (addr >= FB && addr < FB + FR) begin
      m_out = m_mem[WC + addr - FB];
    end else begin
      for (int k = 0; k < VL; k++) m_out[k] = '0;
`ifdef FWM_ADDR_CHECK_EN
      m_err = 1;
`endif
    end
    return 1'b1;
  endfunction

  task automatic check_outputs(input string tag, input bit exp_valid);
    check({tag, "_valid"}, data_valid, exp_valid);
    check({tag, "_data"}, pack(data_out), pack(m_out));
    check({tag, "_err"}, addr_err, m_err);
  endtask

  task automatic cycle_read(input bit en, input int addr, input string tag);
    bit ev;
    read_en      = en;
    read_address = 13'(addr);
    ev = expect_read(en, addr);
    tick();
    read_en = 1'b0;
    check_outputs(tag, ev);
  endtask

  function automatic int rand_addr();
    int sel;
    int edge_addrs [4] = '{3, 'h206, 'h1FF, 'h1FFF};
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return WB + $urandom_range(0, WC - 1);
      1:       return FB + $urandom_range(0, FR - 1);
      2:       return edge_addrs[$urandom_range(0, 3)];
      default: return $urandom_range(0, 8191);
    endcase
  endfunction

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++)
      cycle_read($urandom_range(0, 3) != 0, rand_addr(), "rnd_read");
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic reset_mid_cycle();
    load_valid = 1'b0;
    read_en    = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_ready", load_ready, 0);
    check("rst_done", load_done, 0);
    check("rst_loaded", mem_loaded, 0);
    check_outputs("rst", 1'b0);
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic do_load(input bit rnd, input bit gaps, input bit with_read,
                         input int rd_elem, input int abort_elem);
    bit            ev;
    int            c;
    int            k;
    logic [EW-1:0] v;
    load_start   = 1'b1;
    read_en      = with_read;
    read_address = 13'(WB);
    ev = expect_read(with_read, WB);
    tick();
    load_start = 1'b0;
    read_en    = 1'b0;
    m_loaded   = 0;
    m_err      = 0;
    check_outputs("ld_start", ev);
    check("ld_start_loaded", mem_loaded, 0);
    check("ld_start_ready", load_ready, 1);
    for (int e = 0; e < NE; e++) begin
      if (e == abort_elem) begin
        reset_mid_cycle();
        return;
      end
      if (gaps) begin
        load_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      c = e / VL;
      k = e % VL;
      if (rnd) v = EW'($urandom);
      else if (c < WC) v = EW'((c + k) % 32);
      else v = EW'((3 * (c - WC) + k) % 32);
      load_valid = 1'b1;
      load_data  = v;
      ev = 1'b0;
      if (e == rd_elem) begin
        read_en      = 1'b1;
        read_address = 13'(rand_addr());
        ev = expect_read(1'b1, int'(read_address));
      end
      tick();
      read_en = 1'b0;
      m_mem[c][k] = v;
      if (e == rd_elem) check_outputs("ld_read", ev);
      check("ld_done", load_done, e == NE - 1);
      check("ld_loaded", mem_loaded, e == NE - 1);
      check("ld_ready", load_ready, e != NE - 1);
    end
    load_valid = 1'b0;
    m_loaded   = 1;
    tick();
    check("ld_done_pulse", load_done, 0);
    check("ld_loaded_hold", mem_loaded, 1);
    check_outputs("ld_idle", 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    load_start   = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    read_en      = 1'b0;
    read_address = '0;
    model_reset();
    #1 reset = 1'b0;
    #11;
    check("reset_ready", load_ready, 0);
    check("reset_done", load_done, 0);
    check("reset_loaded", mem_loaded, 0);
    check_outputs("reset", 1'b0);
    #1 reset = 1'b1;
    tick();

    // Reads before any load are ignored.
    cycle_read(1'b1, 1, "idle_read");

    // Deterministic pattern, valid held high, a read attempt at entry 2 element 40.
    do_load(1'b0, 1'b0, 1'b0, 2 * VL + 40, -1);

    // Back-to-back reads, then out-of-range reads, then an idle cycle that must hold data.
    cycle_read(1'b1, 'h001, "w1_read");
    cycle_read(1'b1, 'h205, "f5_read");
    cycle_read(1'b1, 'h003, "oor_w_read");
    cycle_read(1'b1, 'h206, "oor_f_read");
    cycle_read(1'b1, 'h000, "w0_read");
    cycle_read(1'b0, 'h000, "hold");
    random_reads(200);

    // Reload with random data started by a coincident read of weight column 0.
    do_load(1'b1, 1'b1, 1'b1, -1, -1);
    cycle_read(1'b1, 'h000, "w0_new");
    random_reads(150);

    // Abandon a load at entry 4, confirm reads are ignored, then reload fully.
    do_load(1'b1, 1'b0, 1'b0, -1, 4 * VL + 10);
    cycle_read(1'b1, 'h001, "post_rst_read");
    cycle_read(1'b1, 'h202, "post_rst_read2");
    do_load(1'b1, 1'b1, 1'b0, 7 * VL + 3, -1);
    random_reads(150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
